vector_mem_access_stage: RTL and testbench
==========================================

Name: vector_mem_access_stage

Overview:
- Memory stage of the vector pipeline. Sits directly downstream of the EX/MEM segment register and upstream of the MEM/WB segment.
- Takes a vector load or store request (R lanes of N bits). Serialises it into one lane access per cycle on a narrow N-bit data memory port.
- Stalls the pipeline until the access completes, then presents the assembled load vector.
- Scalar requests touch only lane 0.

Parameters:
- I, 32, address width
- N, 8, lane data width
- R, 6, number of vector lanes (R >= 1)

Ports:
- clk  in  1  clock; block is rising-edge sequential
- reset  in  1  asynchronous, active-high reset
- MemWriteM  in  1  store request from EX/MEM segment
- MemtoRegM  in  1  load request from EX/MEM segment
- ScalarM  in  1  1 = scalar access (lane 0 only); 0 = full vector
- AddressM  in  I  base address
- WriteDataM  in  R*N  store data, lane k at bits [k*N +: N]
- StallM  out  1  freeze upstream stages and EX/MEM segment
- ReadDataM  out  R*N  assembled load vector
- ReadValidM  out  1  one-cycle pulse: ReadDataM updated by a completed load
- mem_addr  out  I  memory port address
- mem_wdata  out  N  memory port write data
- mem_we  out  1  memory port write enable
- mem_rdata  in  N  memory port read data, valid the cycle after mem_addr is presented

Behaviour:
- Reset, asynchronous, takes effect immediately, including mid-access:
  - state = IDLE, lane counter = 0
  - StallM = 0, ReadValidM = 0, mem_we = 0
  - mem_addr = 0, mem_wdata = 0, ReadDataM = 0
- States: IDLE, WRITE, READ, RDWAIT, DONE.
- Beat count B = 1 if ScalarM, else R. B and ScalarM are captured at request acceptance.
- IDLE, request present (MemWriteM | MemtoRegM):
  - StallM = 1 combinationally in the same cycle
  - at the clock edge, latch AddressM, WriteDataM, op and B; lane counter k = 0
  - next state: WRITE if MemWriteM, else READ
  - if both MemWriteM and MemtoRegM are asserted, the store wins and no load is performed
- IDLE, no request: StallM = 0, mem_we = 0.
- WRITE:
  - mem_we = 1, mem_addr = base + k, mem_wdata = lane k
  - k increments each cycle; after k = B-1 go to DONE
- READ:
  - mem_we = 0, mem_addr = base + k
  - data for beat k-1 (if k > 0) is captured from mem_rdata into ReadDataM lane k-1
  - after k = B-1 go to RDWAIT
- RDWAIT:
  - capture the last lane (B-1) from mem_rdata, go to DONE
  - lanes >= B are written 0 (scalar load zero-extends the vector)
- DONE:
  - StallM = 0; ReadValidM = 1 if the op was a load
  - request inputs are ignored (they still hold the finished instruction); go to IDLE
- StallM is 1 in WRITE, READ and RDWAIT.
- Total stall cycles from the request cycle:
  - store: B+1
  - load: B+2
- ReadDataM holds its value until the next completed load; stores do not alter it.
- Address arithmetic is modulo 2^I: base + k wraps past all-ones to 0.
- mem_addr and mem_wdata hold their last value when the port is idle. mem_we is 0 in every state except WRITE.

Optional Feature:
- Macro VMEM_STRIDE_EN.
- Defined:
  - adds input StrideM (width I), latched with AddressM at request acceptance
  - lane k address = base + k*StrideM, modulo 2^I
  - StrideM = 0 makes every lane hit the same address
- Undefined: StrideM port absent; lane k address = base + k (unit stride).

Test Plan:
- Reset mid-store: assert reset during WRITE beat 3 -> mem_we=0, StallM=0, state IDLE immediately, before the next clock edge.
- Vector store, R=6, N=8, AddressM=0x100, WriteDataM lanes 0x11..0x66:
  - mem_we=1 on 6 consecutive cycles, addresses 0x100..0x105 with data 0x11..0x66
  - StallM high for 7 cycles, then low
- Vector load from 0x200, memory model returning 0xA0+offset:
  - ReadDataM lanes = 0xA0..0xA5
  - ReadValidM pulses once, 8 cycles after the request cycle
- Scalar load from 0x300 (mem 0x5C) after a prior vector load:
  - ReadDataM lane0 = 0x5C, lanes 1..5 = 0
  - stall lasts 3 cycles
- Wrap and conflict:
  - vector store at AddressM=0xFFFFFFFE -> lane addresses FFFFFFFE, FFFFFFFF, 0, 1, 2, 3
  - MemWriteM and MemtoRegM both 1 -> store only, no ReadValidM
- VMEM_STRIDE_EN: load base 0x40, StrideM=4 -> addresses 0x40, 0x44, …, 0x54.

Source files
------------

// File: rtl/vector_mem_access_stage.sv
// Purpose : vector memory stage; serialises an R-lane load/store into one N-bit lane access per cycle.
// Latency : store stalls B+1 cycles, load stalls B+2 cycles (B = 1 scalar, R vector); ReadValidM in DONE.
// Backpress: StallM freezes upstream and the EX/MEM segment while the access is in flight.
//
// Ports:
//   clk, reset         rising-edge clock, asynchronous active-high reset
//   MemWriteM/MemtoRegM store / load request from EX/MEM (store wins if both are set)
//   ScalarM            1 = lane 0 only, 0 = all R lanes
//   AddressM           base address, WriteDataM store vector (lane k at [k*N +: N])
//   StrideM            lane address stride (present only with VMEM_STRIDE_EN)
//   StallM             pipeline freeze
//   ReadDataM          assembled load vector, ReadValidM one-cycle completion pulse
//   mem_addr/mem_wdata/mem_we/mem_rdata  narrow memory port (read data one cycle after address)
//
// Build option: define VMEM_STRIDE_EN to add StrideM (lane k address = base + k*StrideM).
module vector_mem_access_stage #(
  parameter int I = 32,
  parameter int N = 8,
  parameter int R = 6
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           MemWriteM,
  input  logic           MemtoRegM,
  input  logic           ScalarM,
  input  logic [I-1:0]   AddressM,
  input  logic [R*N-1:0] WriteDataM,
`ifdef VMEM_STRIDE_EN
  input  logic [I-1:0]   StrideM,
`endif
  output logic           StallM,
  output logic [R*N-1:0] ReadDataM,
  output logic           ReadValidM,
  output logic [I-1:0]   mem_addr,
  output logic [N-1:0]   mem_wdata,
  output logic           mem_we,
  input  logic [N-1:0]   mem_rdata
);

  localparam int KW = (R > 1) ? $clog2(R) : 1;

  typedef enum logic [2:0] {IDLE, WRITE, READ, RDWAIT, DONE} state_t;

  state_t         state_q;
  logic [KW-1:0]  k_q;
  logic [KW-1:0]  last_q;       // index of the final beat (B-1)
  logic [I-1:0]   step_q;       // address increment between lanes
  logic [I-1:0]   mem_addr_q;
  logic [N-1:0]   mem_wdata_q;
  logic           mem_we_q;
  logic [R*N-1:0] wdata_q;
  logic [R*N-1:0] rdata_q;
  logic           rvalid_q;

  logic           req;
  logic           last_beat;
  logic [KW-1:0]  k_d;
  logic [I-1:0]   mem_addr_d;

  assign req        = MemWriteM | MemtoRegM;
  assign last_beat  = (k_q == last_q);
  assign k_d        = k_q + KW'(1);
  // Incremental address walk: base + k*stride without a multiplier, wrapping modulo 2^I.
  assign mem_addr_d = mem_addr_q + step_q;

  // Stall rises combinationally in the request cycle so the EX/MEM segment holds the instruction.
  assign StallM = !reset && ((state_q == IDLE && req) || state_q == WRITE ||
                             state_q == READ || state_q == RDWAIT);

  assign ReadDataM  = rdata_q;
  assign ReadValidM = rvalid_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_we     = mem_we_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      k_q         <= '0;
      last_q      <= '0;
      step_q      <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            k_q        <= '0;
            last_q     <= ScalarM ? '0 : KW'(R - 1);
            mem_addr_q <= AddressM;
            wdata_q    <= WriteDataM;
`ifdef VMEM_STRIDE_EN
            step_q     <= StrideM;
`else
            step_q     <= I'(1);
`endif
            if (MemWriteM) begin
              mem_we_q    <= 1'b1;
              mem_wdata_q <= WriteDataM[N-1:0];
              state_q     <= WRITE;
            end else begin
              state_q <= READ;
            end
          end
        end

        WRITE: begin
          if (last_beat) begin
            mem_we_q <= 1'b0;
            state_q  <= DONE;
          end else begin
            k_q         <= k_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= wdata_q[int'(k_d)*N +: N];
          end
        end

        READ: begin
          // Memory answers one cycle late: this cycle's mem_rdata belongs to beat k-1.
          if (k_q != '0) begin
            rdata_q[(int'(k_q) - 1)*N +: N] <= mem_rdata;
          end
          if (last_beat) begin
            state_q <= RDWAIT;
          end else begin
            k_q        <= k_d;
            mem_addr_q <= mem_addr_d;
          end
        end

        RDWAIT: begin
          // Final beat lands here; lanes beyond B are cleared so a scalar load zero-extends.
          for (int l = 0; l < R; l++) begin
            if (l == int'(last_q)) begin
              rdata_q[l*N +: N] <= mem_rdata;
            end else if (l > int'(last_q)) begin
              rdata_q[l*N +: N] <= '0;
            end
          end
          rvalid_q <= 1'b1;
          state_q  <= DONE;
        end

        DONE: begin
          // Inputs still show the finished instruction this cycle; do not re-accept it.
          state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_mem_access_stage.sv
module tb_vector_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWriteM, MemtoRegM, ScalarM;
  logic [31:0] AddressM;
  logic [47:0] WriteDataM;
  logic        StallM;
  logic [47:0] ReadDataM;
  logic        ReadValidM;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata = 8'h00;
`ifdef VMEM_STRIDE_EN
  logic [31:0] StrideM = 32'd1;
`endif

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int rv_count = 0;
  int rv_cyc = 0;

  typedef struct {
    logic [31:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t         exp_wr[$];
  logic [47:0] exp_rd[$];

  vector_mem_access_stage #(.I(32), .N(8), .R(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemWriteM  (MemWriteM),
    .MemtoRegM  (MemtoRegM),
    .ScalarM    (ScalarM),
    .AddressM   (AddressM),
    .WriteDataM (WriteDataM),
`ifdef VMEM_STRIDE_EN
    .StrideM    (StrideM),
`endif
    .StallM     (StallM),
    .ReadDataM  (ReadDataM),
    .ReadValidM (ReadValidM),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Memory model: 0x300 holds 0x5C, every other address returns 0xA0 + low address byte.
  function automatic logic [7:0] mem_func(input logic [31:0] a);
    if (a == 32'h300) return 8'h5C;
    return 8'hA0 + a[7:0];
  endfunction

  always @(posedge clk) mem_rdata <= mem_func(mem_addr);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Scoreboard side: every write beat and every load completion is popped and compared.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (exp_wr.size() == 0) begin
        check("unexpected_write", 64'(mem_addr), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        wr_t w;
        w = exp_wr.pop_front();
        check("wr_addr", 64'(mem_addr), 64'(w.a));
        check("wr_data", 64'(mem_wdata), 64'(w.d));
      end
    end
    if (ReadValidM === 1'b1) begin
      rv_count++;
      rv_cyc = cyc;
      if (exp_rd.size() == 0) begin
        check("unexpected_rvalid", 64'(ReadDataM), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        check("rd_vector", 64'(ReadDataM), 64'(exp_rd.pop_front()));
      end
    end
  end

  task automatic push_store(input logic [31:0] addr, input logic [47:0] wd, input int beats);
    for (int k = 0; k < beats; k++) begin
      wr_t w;
      w.a = addr + 32'(k);
      w.d = wd[k*8 +: 8];
      exp_wr.push_back(w);
    end
  endtask

  // Drives one request, holds it while stalled, then checks stall length and load timing.
  task automatic run_op(input string tag, input logic we, input logic ld, input logic sc,
                        input logic [31:0] addr, input logic [47:0] wd,
                        input int exp_stall, input int exp_rv_delay);
    int rv_before;
    int req_cyc;
    int st;
    rv_before = rv_count;
    st = 0;
    @(posedge clk); #1;
    MemWriteM = we; MemtoRegM = ld; ScalarM = sc; AddressM = addr; WriteDataM = wd;
    req_cyc = cyc;
    forever begin
      @(negedge clk);
      if (StallM !== 1'b1) break;
      st++;
      if (st > 40) break;
    end
    check({tag, "_stall"}, 64'(st), 64'(exp_stall));
    @(posedge clk); #1;
    MemWriteM = 1'b0; MemtoRegM = 1'b0; ScalarM = 1'b0;
    if (exp_rv_delay >= 0) begin
      check({tag, "_rv_count"}, 64'(rv_count - rv_before), 64'd1);
      check({tag, "_rv_delay"}, 64'(rv_cyc - req_cyc), 64'(exp_rv_delay));
    end else begin
      check({tag, "_no_rv"}, 64'(rv_count - rv_before), 64'd0);
    end
  endtask

  initial begin
    reset = 1'b1;
    MemWriteM = 1'b0; MemtoRegM = 1'b0; ScalarM = 1'b0;
    AddressM = '0; WriteDataM = '0;
    #3;
    check("rst_stall", 64'(StallM), 64'd0);
    check("rst_we", 64'(mem_we), 64'd0);
    check("rst_rvalid", 64'(ReadValidM), 64'd0);
    check("rst_addr", 64'(mem_addr), 64'd0);
    check("rst_rdata", 64'(ReadDataM), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Vector store 0x100, lanes 0x11..0x66.
    push_store(32'h100, 48'h665544332211, 6);
    run_op("vst", 1'b1, 1'b0, 1'b0, 32'h100, 48'h665544332211, 7, -1);
    check("vst_wdata_hold", 64'(mem_wdata), 64'h66);

    // Vector load 0x200 -> A0..A5, ReadValidM 8 cycles after request.
    exp_rd.push_back(48'hA5A4A3A2A1A0);
    run_op("vld", 1'b0, 1'b1, 1'b0, 32'h200, 48'h0, 8, 8);

    // Scalar load 0x300 -> lane0 5C, upper lanes cleared.
    exp_rd.push_back(48'h00000000005C);
    run_op("sld", 1'b0, 1'b1, 1'b1, 32'h300, 48'h0, 3, 3);

    // Vector store across the address wrap; must not disturb ReadDataM.
    push_store(32'hFFFF_FFFE, 48'hF0E0D0C0B0A0, 6);
    run_op("wrap", 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE, 48'hF0E0D0C0B0A0, 7, -1);
    check("wrap_rdata_kept", 64'(ReadDataM), 64'h5C);

    // Store and load together: store only.
    push_store(32'h400, 48'h0605040302A1, 6);
    run_op("conflict", 1'b1, 1'b1, 1'b0, 32'h400, 48'h0605040302A1, 7, -1);

    // Scalar store touches only lane 0.
    push_store(32'h480, 48'h0000000000E7, 1);
    run_op("sst", 1'b1, 1'b0, 1'b1, 32'h480, 48'hFFFFFFFFFFE7, 2, -1);

`ifdef VMEM_STRIDE_EN
    StrideM = 32'd4;
    exp_rd.push_back(48'hF4F0ECE8E4E0);
    run_op("stride", 1'b0, 1'b1, 1'b0, 32'h40, 48'h0, 8, 8);
    StrideM = 32'd1;
`endif

    // Reset during WRITE beat 3: only beats 0..2 reach the port.
    push_store(32'h500, 48'h343332313029, 3);
    @(posedge clk); #1;
    MemWriteM = 1'b1; AddressM = 32'h500; WriteDataM = 48'h343332313029;
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("mrst_we", 64'(mem_we), 64'd0);
    check("mrst_stall", 64'(StallM), 64'd0);
    check("mrst_addr", 64'(mem_addr), 64'd0);
    check("mrst_wdata", 64'(mem_wdata), 64'd0);
    check("mrst_rdata", 64'(ReadDataM), 64'd0);
    MemWriteM = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_stall", 64'(StallM), 64'd0);
    check("post_rst_we", 64'(mem_we), 64'd0);

    repeat (2) @(negedge clk);
    check("wr_queue_empty", 64'(exp_wr.size()), 64'd0);
    check("rd_queue_empty", 64'(exp_rd.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
